// File: rtl/adcavg.sv
// Windowed averager for converter reports: averages 1/4/16/64 samples of one channel,
// classifies the mean against HI/LO thresholds and raises W1C status/interrupt.
// Optional min/max peak tracking is built in when ADCAVG_PEAK_EN is defined.
module adcavg #(
    parameter int BIT_PTR = 5
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               rpt_vld,
    input  logic [BIT_PTR-1:0] rpt_ch,
    input  logic [9:0]         rpt_v,
    input  logic [3:0]         r_wr,
    input  logic [7:0]         r_wdat,
    output logic [7:0]         o_avctl,
    output logic [7:0]         o_thh,
    output logic [7:0]         o_thl,
    output logic [9:0]         o_avg,
    output logic               o_avg_vld,
    output logic [1:0]         o_zone,
    output logic [7:0]         o_sta,
    output logic               o_busy,
    output logic               o_intr,
    output logic [15:0]        o_peak
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EVAL = 2'd2
    } state_t;

    localparam logic [1:0] Z_MID   = 2'b00;
    localparam logic [1:0] Z_BELOW = 2'b01;
    localparam logic [1:0] Z_ABOVE = 2'b10;

    // Truncating divide by 4**nsel.
    function automatic logic [9:0] mean_of(input logic [15:0] acc, input logic [1:0] nsel);
        logic [9:0] m;
        case (nsel)
            2'd0:    m = acc[9:0];
            2'd1:    m = acc[11:2];
            2'd2:    m = acc[13:4];
            default: m = acc[15:6];
        endcase
        return m;
    endfunction

    // Above has priority so an inverted threshold pair still classifies deterministically.
    function automatic logic [1:0] classify(input logic [7:0] a8, input logic [7:0] thh,
                                            input logic [7:0] thl);
        logic [1:0] z;
        if (a8 > thh)      z = Z_ABOVE;
        else if (a8 < thl) z = Z_BELOW;
        else               z = Z_MID;
        return z;
    endfunction

    state_t       state_q, state_d;
    logic [7:0]   avctl_q, avctl_d;
    logic [7:0]   thh_q, thh_d;
    logic [7:0]   thl_q, thl_d;
    logic [9:0]   avg_q, avg_d;
    logic [1:0]   zone_q, zone_d;
    logic [3:0]   sta_q, sta_d;
    logic         avg_vld_q, avg_vld_d;
    logic [15:0]  acc_q, acc_d;
    logic [5:0]   cnt_q, cnt_d;

    logic [BIT_PTR-1:0] sel_ch;
    logic [1:0]   nsel;
    logic         accept;
    logic [6:0]   n_target;
    logic [6:0]   cnt_next;
    logic [9:0]   avg_new;
    logic [1:0]   zone_new;
    logic         up_evt, dn_evt;
    logic [3:0]   sta_set;
    logic         publish, win_open, smp_take;

    assign sel_ch   = BIT_PTR'(avctl_q[4:0]);
    assign nsel     = avctl_q[6:5];
    assign accept   = rpt_vld && (rpt_ch == sel_ch) && avctl_q[7];
    assign n_target = 7'd1 << {nsel, 1'b0};
    assign cnt_next = {1'b0, cnt_q} + 7'd1;
    assign avg_new  = mean_of(acc_q, nsel);
    assign zone_new = classify(avg_new[9:2], thh_q, thl_q);
    assign up_evt   = (zone_new == Z_ABOVE) && (zone_q != Z_ABOVE);
    assign dn_evt   = (zone_new == Z_BELOW) && (zone_q != Z_BELOW);

    // A control write pre-empts both the publish and any sample in the same cycle.
    assign publish  = (state_q == EVAL) && !r_wr[0];
    assign win_open = (state_q == EVAL) || r_wr[0];
    assign smp_take = accept && !r_wr[0] && (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        avctl_d   = avctl_q;
        thh_d     = thh_q;
        thl_d     = thl_q;
        avg_d     = avg_q;
        zone_d    = zone_q;
        avg_vld_d = 1'b0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sta_set   = 4'h0;

        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_q + 16'(rpt_v);
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_next == n_target) state_d = EVAL;
                end
            end
            EVAL: begin
                avg_d     = avg_new;
                zone_d    = zone_new;
                avg_vld_d = 1'b1;
                sta_set   = {sta_q[0], dn_evt, up_evt, 1'b1};
                state_d   = ACC;
                if (accept) begin
                    acc_d = 16'(rpt_v);
                    cnt_d = 6'd1;
                    if (n_target == 7'd1) state_d = EVAL;
                end else begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (r_wr[0]) begin
            avctl_d   = r_wdat;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = r_wdat[7] ? ACC : IDLE;
            avg_d     = avg_q;
            zone_d    = zone_q;
            avg_vld_d = 1'b0;
            sta_set   = 4'h0;
        end
        if (r_wr[1]) thh_d = r_wdat;
        if (r_wr[2]) thl_d = r_wdat;

        sta_d = (sta_q & ~(r_wr[3] ? r_wdat[3:0] : 4'h0)) | sta_set;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            avctl_q   <= '0;
            thh_q     <= '0;
            thl_q     <= '0;
            avg_q     <= '0;
            zone_q    <= '0;
            sta_q     <= '0;
            avg_vld_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            avctl_q   <= avctl_d;
            thh_q     <= thh_d;
            thl_q     <= thl_d;
            avg_q     <= avg_d;
            zone_q    <= zone_d;
            sta_q     <= sta_d;
            avg_vld_q <= avg_vld_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ADCAVG_PEAK_EN
    logic [7:0]  mn_q, mn_d, mx_q, mx_d;
    logic [15:0] peak_q, peak_d;
    logic [7:0]  mn_b, mx_b, s8;

    always_comb begin
        s8     = rpt_v[9:2];
        mn_b   = win_open ? 8'hff : mn_q;
        mx_b   = win_open ? 8'h00 : mx_q;
        mn_d   = (smp_take && (s8 < mn_b)) ? s8 : mn_b;
        mx_d   = (smp_take && (s8 > mx_b)) ? s8 : mx_b;
        peak_d = publish ? {mx_q, mn_q} : peak_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mn_q   <= 8'hff;
            mx_q   <= 8'h00;
            peak_q <= 16'h00ff;
        end else begin
            mn_q   <= mn_d;
            mx_q   <= mx_d;
            peak_q <= peak_d;
        end
    end

    assign o_peak = peak_q;
`else
    logic unused_peak;
    assign unused_peak = publish ^ win_open ^ smp_take;
    assign o_peak      = 16'h0000;
`endif

    assign o_avctl   = avctl_q;
    assign o_thh     = thh_q;
    assign o_thl     = thl_q;
    assign o_avg     = avg_q;
    assign o_avg_vld = avg_vld_q;
    assign o_zone    = zone_q;
    assign o_sta     = {4'h0, sta_q};
    assign o_busy    = (state_q != IDLE);
    assign o_intr    = |sta_q;

endmodule

// File: tb/tb_adcavg.sv
// Bench for adcavg: directed vector table, hand sequences for window corner cases,
// and randomized traffic against a queue-based reference model.
module tb_adcavg;

    logic        clk = 1'b0;
    logic        arst;
    logic        rpt_vld;
    logic [4:0]  rpt_ch;
    logic [9:0]  rpt_v;
    logic [3:0]  r_wr;
    logic [7:0]  r_wdat;
    logic [7:0]  o_avctl, o_thh, o_thl, o_sta;
    logic [9:0]  o_avg;
    logic        o_avg_vld, o_busy, o_intr;
    logic [1:0]  o_zone;
    logic [15:0] o_peak;

    adcavg #(.BIT_PTR(5)) dut (
        .clk(clk), .arst(arst), .rpt_vld(rpt_vld), .rpt_ch(rpt_ch), .rpt_v(rpt_v),
        .r_wr(r_wr), .r_wdat(r_wdat), .o_avctl(o_avctl), .o_thh(o_thh), .o_thl(o_thl),
        .o_avg(o_avg), .o_avg_vld(o_avg_vld), .o_zone(o_zone), .o_sta(o_sta),
        .o_busy(o_busy), .o_intr(o_intr), .o_peak(o_peak)
    );

    always #5 clk = ~clk;

`ifdef ADCAVG_PEAK_EN
    localparam logic [15:0] PEAK_RST = 16'h00ff;
`else
    localparam logic [15:0] PEAK_RST = 16'h0000;
`endif

    int nchk = 0;
    int nerr = 0;

    // Reference model: a window is just the list of accepted values.
    int          m_win[$];
    int          m_closed[$];
    bit          m_eval;
    logic [7:0]  m_ctl, m_thh, m_thl;
    logic [9:0]  m_avg;
    logic [1:0]  m_zone;
    logic [3:0]  m_sta;
    bit          m_vld;
    logic [15:0] m_peak;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win.delete();
        m_closed.delete();
        m_eval = 0;
        m_ctl = 0; m_thh = 0; m_thl = 0;
        m_avg = 0; m_zone = 0; m_sta = 0; m_vld = 0;
        m_peak = PEAK_RST;
    endtask

    task automatic model_step(input logic [3:0] wr, input logic [7:0] wd, input logic rv,
                              input logic [4:0] rc, input logic [9:0] v);
        bit         accept;
        bit         pend;
        logic [3:0] set;
        int         sum, mean, a8, mn, mx;
        logic [1:0] z;
        set    = 0;
        pend   = m_eval;
        m_vld  = 0;
        accept = rv && (rc == m_ctl[4:0]) && m_ctl[7];
        if (wr[0]) begin
            m_ctl = wd;
            m_win.delete();
            m_eval = 0;
        end else begin
            if (pend) begin
                sum = 0; mn = 255; mx = 0;
                foreach (m_closed[i]) begin
                    sum += m_closed[i];
                    if ((m_closed[i] >> 2) < mn) mn = m_closed[i] >> 2;
                    if ((m_closed[i] >> 2) > mx) mx = m_closed[i] >> 2;
                end
                mean = sum / m_closed.size();
                a8   = mean >> 2;
                if (a8 > int'(m_thh))      z = 2'b10;
                else if (a8 < int'(m_thl)) z = 2'b01;
                else                       z = 2'b00;
                set[0] = 1;
                set[1] = (z == 2'b10) && (m_zone != 2'b10);
                set[2] = (z == 2'b01) && (m_zone != 2'b01);
                set[3] = m_sta[0];
                m_avg  = 10'(mean);
                m_zone = z;
                m_vld  = 1;
`ifdef ADCAVG_PEAK_EN
                m_peak = {8'(mx), 8'(mn)};
`endif
                m_eval = 0;
            end
            if (accept) begin
                m_win.push_back(int'(v));
                if (m_win.size() == (1 << (2 * int'(m_ctl[6:5])))) begin
                    m_closed = m_win;
                    m_win.delete();
                    m_eval = 1;
                end
            end
        end
        m_sta = (m_sta & ~(wr[3] ? wd[3:0] : 4'h0)) | set;
        if (wr[1]) m_thh = wd;
        if (wr[2]) m_thl = wd;
    endtask

    task automatic compare_all();
        chk("avctl", 32'(o_avctl), 32'(m_ctl));
        chk("thh", 32'(o_thh), 32'(m_thh));
        chk("thl", 32'(o_thl), 32'(m_thl));
        chk("avg", 32'(o_avg), 32'(m_avg));
        chk("avg_vld", 32'(o_avg_vld), 32'(m_vld));
        chk("zone", 32'(o_zone), 32'(m_zone));
        chk("sta", 32'(o_sta), {28'h0, m_sta});
        chk("busy", 32'(o_busy), 32'(m_ctl[7]));
        chk("intr", 32'(o_intr), 32'(|m_sta));
        chk("peak", 32'(o_peak), 32'(m_peak));
    endtask

    task automatic step(input logic [3:0] wr, input logic [7:0] wd, input logic rv,
                        input logic [4:0] rc, input logic [9:0] v);
        r_wr = wr; r_wdat = wd; rpt_vld = rv; rpt_ch = rc; rpt_v = v;
        @(posedge clk);
        #1;
        model_step(wr, wd, rv, rc, v);
        r_wr = 0; rpt_vld = 0;
        compare_all();
    endtask

    task automatic idle();
        step(4'h0, 8'h00, 1'b0, 5'd0, 10'd0);
    endtask

    typedef struct {
        logic [3:0] wr;
        logic [7:0] wd;
        logic       rv;
        logic [4:0] rc;
        logic [9:0] v;
        logic [9:0] e_avg;
        logic       e_vld;
        logic [1:0] e_zone;
        logic [7:0] e_sta;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] wr, input logic [7:0] wd, input logic rv,
                       input logic [4:0] rc, input logic [9:0] v, input logic [9:0] ea,
                       input logic ev, input logic [1:0] ez, input logic [7:0] es,
                       input logic eb);
        vec_t r;
        r.wr = wr; r.wd = wd; r.rv = rv; r.rc = rc; r.v = v;
        r.e_avg = ea; r.e_vld = ev; r.e_zone = ez; r.e_sta = es; r.e_busy = eb;
        tbl.push_back(r);
    endtask

    initial begin
        logic [3:0] wr;
        logic [7:0] wd;
        logic [9:0] v2;

        arst = 1'b1; rpt_vld = 0; rpt_ch = 0; rpt_v = 0; r_wr = 0; r_wdat = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        arst = 1'b0;

        // single sample, 4-sample window with foreign channel, threshold zones
        add(4'b0010, 8'hff, 0, 0, 0,         10'h000, 0, 2'b00, 8'h00, 0);
        add(4'b0001, 8'h83, 0, 0, 0,         10'h000, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 3, 10'h155,   10'h000, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 0, 0, 0,         10'h155, 1, 2'b00, 8'h01, 1);
        add(4'b0000, 8'h00, 0, 0, 0,         10'h155, 0, 2'b00, 8'h01, 1);
        add(4'b1000, 8'h0f, 0, 0, 0,         10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0001, 8'ha2, 0, 0, 0,         10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 2, 10'd100,   10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 5, 10'd300,   10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 2, 10'd101,   10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 5, 10'd7,     10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 2, 10'd102,   10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 2, 10'd104,   10'h155, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 0, 0, 0,         10'd101, 1, 2'b00, 8'h01, 1);
        add(4'b0010, 8'h80, 0, 0, 0,         10'd101, 0, 2'b00, 8'h01, 1);
        add(4'b0100, 8'h40, 0, 0, 0,         10'd101, 0, 2'b00, 8'h01, 1);
        add(4'b1000, 8'h0f, 0, 0, 0,         10'd101, 0, 2'b00, 8'h00, 1);
        add(4'b0001, 8'h83, 0, 0, 0,         10'd101, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 1, 3, 10'h300,   10'd101, 0, 2'b00, 8'h00, 1);
        add(4'b0000, 8'h00, 0, 0, 0,         10'h300, 1, 2'b10, 8'h03, 1);
        add(4'b0000, 8'h00, 1, 3, 10'h300,   10'h300, 0, 2'b10, 8'h03, 1);
        add(4'b0000, 8'h00, 0, 0, 0,         10'h300, 1, 2'b10, 8'h0b, 1);
        add(4'b0000, 8'h00, 1, 3, 10'h080,   10'h300, 0, 2'b10, 8'h0b, 1);
        add(4'b0000, 8'h00, 0, 0, 0,         10'h080, 1, 2'b01, 8'h0f, 1);
        add(4'b1000, 8'h0f, 0, 0, 0,         10'h080, 0, 2'b01, 8'h00, 1);

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].wd, tbl[i].rv, tbl[i].rc, tbl[i].v);
            chk($sformatf("tbl%0d_avg", i), 32'(o_avg), 32'(tbl[i].e_avg));
            chk($sformatf("tbl%0d_vld", i), 32'(o_avg_vld), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_zone", i), 32'(o_zone), 32'(tbl[i].e_zone));
            chk($sformatf("tbl%0d_sta", i), 32'(o_sta), 32'(tbl[i].e_sta));
            chk($sformatf("tbl%0d_intr", i), 32'(o_intr), 32'(|tbl[i].e_sta));
            chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].e_busy));
        end

        // window restart mid-way, then 16 full-scale samples
        step(4'b0001, 8'hc1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(4'h0, 8'h00, 1, 1, 10'($urandom_range(0, 1023)));
        step(4'b0001, 8'hc1, 1, 1, 10'h000);
        for (int i = 0; i < 16; i++) step(4'h0, 8'h00, 1, 1, 10'h3ff);
        chk("restart_vld_early", 32'(o_avg_vld), 32'h0);
        idle();
        chk("restart_avg", 32'(o_avg), 32'h3ff);
        chk("restart_vld", 32'(o_avg_vld), 32'h1);

        // disable mid-window
        for (int i = 0; i < 5; i++) step(4'h0, 8'h00, 1, 1, 10'h011);
        step(4'b0001, 8'h41, 0, 0, 0);
        chk("dis_busy", 32'(o_busy), 32'h0);
        chk("dis_avg_held", 32'(o_avg), 32'h3ff);
        step(4'h0, 8'h00, 1, 1, 10'h222);
        chk("dis_ignored", 32'(o_avg_vld), 32'h0);

        // sample in EVAL together with a clear of rdy
        step(4'b0001, 8'h81, 0, 0, 0);
        step(4'b1000, 8'h0f, 0, 0, 0);
        step(4'h0, 8'h00, 1, 1, 10'h123);
        v2 = 10'h2c4;
        step(4'b1000, 8'h0f, 1, 1, v2);
        chk("eval_clr_rdy", 32'(o_sta[0]), 32'h1);
        chk("eval_clr_avg", 32'(o_avg), 32'h123);
        idle();
        chk("eval_next_avg", 32'(o_avg), 32'(v2));
        chk("eval_next_ovr", 32'(o_sta[3]), 32'h1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            wr = 0;
            wd = 8'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                wr[0] = 1;
                wd = {($urandom_range(0, 7) != 0), 2'($urandom), 5'($urandom_range(0, 3))};
            end else begin
                wr[1] = ($urandom_range(0, 31) == 0);
                wr[2] = ($urandom_range(0, 31) == 0);
                wr[3] = ($urandom_range(0, 15) == 0);
            end
            step(wr, wd, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                 10'($urandom));
        end

        // asynchronous reset mid-window
        step(4'b0001, 8'ha0, 0, 0, 0);
        step(4'h0, 8'h00, 1, 0, 10'h3f0);
        step(4'h0, 8'h00, 1, 0, 10'h010);
        #3;
        arst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("arst_peak", 32'(o_peak), 32'(PEAK_RST));
        @(posedge clk);
        #1;
        arst = 1'b0;
        compare_all();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
